display_scan_controller: RTL and testbench
==========================================

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, giving clock cycles per digit slot (1 kHz per digit at 100 MHz).
REQ-002 SHALL have parameter BLANK_CYCLES, default 16, giving all-anodes-off cycles at the start of each slot; legal range 1 <= BLANK_CYCLES < REFRESH_DIV.
REQ-003 SHALL have port clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high.
REQ-005 SHALL have port value  input  32  eight hex nibbles; nibble k (bits 4k+3:4k) belongs to digit k.
REQ-006 SHALL have port digit_en  input  8  per-digit enable mask; bit k enables digit k.
REQ-007 SHALL have port load  input  1  single-cycle request to capture value and digit_en.
REQ-008 SHALL have port load_ack  output  1  one-cycle pulse when the captured value becomes active.
REQ-009 SHALL have port digit_out  output  4  nibble driven to the existing registered seven_segment_decoder.
REQ-010 SHALL have port AN  output  8  digit anodes, active-low.
REQ-011 SHALL have port frame_tick  output  1  one-cycle pulse at the start of each frame.

Function
REQ-012 SHALL run a two-state FSM, BLANK and SHOW, plus a slot counter and a 3-bit digit index 0..7.
REQ-013 BLANK SHALL last BLANK_CYCLES cycles with AN = 8'hFF, then go to SHOW.
REQ-014 SHOW SHALL last REFRESH_DIV - BLANK_CYCLES cycles, then go to BLANK of the next digit; the index wraps 7 -> 0.
REQ-015 digit_out SHALL take the active nibble of the new index on the first BLANK cycle of each slot and hold it for the whole slot; this absorbs the decoder's one-cycle latency.
REQ-016 In SHOW, AN[k] SHALL be 0 only when k = index and the active enable bit k = 1; all other AN bits SHALL be 1.
REQ-017 A disabled digit SHALL still use its full slot, so brightness is identical for any enable mask.
REQ-018 frame_tick SHALL be high exactly in the first BLANK cycle of digit 0.
REQ-019 A sampled load SHALL copy value and digit_en into a staging register and set pending.
REQ-020 Active value and mask SHALL change only at the frame boundary, so a frame never shows mixed data.
  - The frame boundary is the clock edge that ends the last SHOW cycle of digit 7.
  - At that edge the staging contents are committed and pending is cleared.
REQ-021 Repeated loads before a commit SHALL overwrite staging (last wins) and produce one load_ack.
REQ-022 A load sampled in the boundary cycle itself SHALL be committed at that same edge, taking priority over older staging.
REQ-023 load_ack SHALL pulse in the cycle after a commit, which is the same cycle as frame_tick; no commit means no load_ack.
REQ-024 Input changes to value or digit_en without load SHALL have no effect.

Reset
REQ-025 While reset is high at a rising edge, the block SHALL set:
  - state = BLANK, index = 0, slot counter = 0, pending = 0;
  - active value, staging value = 0; active mask, staging mask = 8'h00;
  - AN = 8'hFF, digit_out = 0, load_ack = 0, frame_tick = 0.
REQ-026 After reset is released, the first cycle SHALL be BLANK of digit 0.
  - frame_tick is not asserted in that cycle.
  - The next frame_tick follows the first full frame.
REQ-027 Reset mid-slot or with pending set SHALL discard staging, produce no load_ack and blank the display immediately.

Structure
REQ-028 Package display_pkg SHALL hold:
  - NUM_DIGITS = 8;
  - the FSM state type (BLANK, SHOW);
  - the constant AN_ALL_OFF = 8'hFF.
REQ-029 No sub-module is required; the slot counter may be factored into sub-module scan_timer, which emits slot_start and show_start strobes.
REQ-030 The block SHALL NOT instantiate the decoder; the top level connects digit_out to it.

Verification
All scenarios use REFRESH_DIV=8 and BLANK_CYCLES=2.
REQ-031 Reset then idle -> AN stays 8'hFF indefinitely (mask 0); frame_tick every 64 cycles; load_ack never pulses.
REQ-032 load with value=32'h76543210 and digit_en=8'hFF, then wait one boundary -> load_ack and frame_tick coincide.
  - Each slot: digit_out = k, AN = ~(8'h01<<k) for 6 cycles, preceded by 2 cycles of 8'hFF.
REQ-033 Mid-frame load with 32'hFFFFFFFF -> the current frame still shows the old digits; the change appears from the next digit-0 slot; load_ack comes one cycle after the boundary.
REQ-034 Three loads in one frame (32'h1, 32'h2, 32'h3) -> a single load_ack; active value = 32'h3.
REQ-035 digit_en=8'b1010_1010 -> AN never drops for even digits; odd digits are low 6 of 8 cycles; the frame stays 64 cycles.
REQ-036 Load in the boundary cycle while older staging is pending -> the boundary-cycle value is committed; reset asserted at slot cycle 4 -> AN = 8'hFF and load_ack = 0 on the next cycle.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and FSM state type for the display scan controller
package display_pkg;
    localparam int NUM_DIGITS = 8;
    localparam logic [7:0] AN_ALL_OFF = 8'hFF;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;
endpackage

// File: rtl/display_scan_controller_scan_timer.sv
// rtl/display_scan_controller_scan_timer.sv - per-slot cycle counter emitting slot/show strobes
module scan_timer #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    output logic slot_start_o,
    output logic show_start_o
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Strobes mark the cycle whose closing edge begins the next slot / the SHOW phase.
    always_comb begin
        slot_start_o = (cnt_q == SLOT_LAST);
        show_start_o = (cnt_q == BLANK_LAST);
        cnt_d        = slot_start_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - multiplexed 8-digit anode scanner with frame-synchronous value updates
module display_scan_controller
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic [7:0]  digit_en,
    input  logic        load,
    output logic        load_ack,
    output logic [3:0]  digit_out,
    output logic [7:0]  AN,
    output logic        frame_tick
);
    logic slot_start;
    logic show_start;
    logic boundary;

    state_t      state_q, state_d;
    logic [2:0]  index_q, index_d;
    logic [31:0] act_val_q, act_val_d;
    logic [7:0]  act_mask_q, act_mask_d;
    logic [31:0] stg_val_q, stg_val_d;
    logic [7:0]  stg_mask_q, stg_mask_d;
    logic        pending_q, pending_d;
    logic [3:0]  digit_q, digit_d;
    logic        ack_q, ack_d;
    logic        tick_q, tick_d;

    scan_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clock        (clock),
        .reset        (reset),
        .slot_start_o (slot_start),
        .show_start_o (show_start)
    );

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        act_val_d  = act_val_q;
        act_mask_d = act_mask_q;
        stg_val_d  = stg_val_q;
        stg_mask_d = stg_mask_q;
        pending_d  = pending_q;

        boundary = slot_start && (state_q == SHOW) && (index_q == 3'd7);

        if (show_start) begin
            state_d = SHOW;
        end
        if (slot_start) begin
            state_d = BLANK;
            index_d = index_q + 3'd1;
        end

        if (load) begin
            stg_val_d  = value;
            stg_mask_d = digit_en;
            pending_d  = 1'b1;
        end

        // A load in the boundary cycle itself wins over whatever was already staged.
        if (boundary) begin
            if (load) begin
                act_val_d  = value;
                act_mask_d = digit_en;
            end else if (pending_q) begin
                act_val_d  = stg_val_q;
                act_mask_d = stg_mask_q;
            end
            pending_d = 1'b0;
        end

        ack_d   = boundary && (load || pending_q);
        tick_d  = boundary;
        // Nibble is presented from the first BLANK cycle so the registered decoder settles before SHOW.
        digit_d = slot_start ? act_val_d[{index_d, 2'b00} +: 4] : digit_q;

        if ((state_q == SHOW) && act_mask_q[index_q]) begin
            AN = ~(8'h01 << index_q);
        end else begin
            AN = AN_ALL_OFF;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= BLANK;
            index_q    <= 3'd0;
            act_val_q  <= 32'h0;
            act_mask_q <= 8'h00;
            stg_val_q  <= 32'h0;
            stg_mask_q <= 8'h00;
            pending_q  <= 1'b0;
            digit_q    <= 4'h0;
            ack_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            act_val_q  <= act_val_d;
            act_mask_q <= act_mask_d;
            stg_val_q  <= stg_val_d;
            stg_mask_q <= stg_mask_d;
            pending_q  <= pending_d;
            digit_q    <= digit_d;
            ack_q      <= ack_d;
            tick_q     <= tick_d;
        end
    end

    assign digit_out  = digit_q;
    assign load_ack   = ack_q;
    assign frame_tick = tick_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - directed self-checking bench for display_scan_controller
module tb_display_scan_controller;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] value;
    logic [7:0]  digit_en;
    logic        load;
    logic        load_ack;
    logic [3:0]  digit_out;
    logic [7:0]  AN;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;

    display_scan_controller #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .value      (value),
        .digit_en   (digit_en),
        .load       (load),
        .load_ack   (load_ack),
        .digit_out  (digit_out),
        .AN         (AN),
        .frame_tick (frame_tick)
    );

    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; load = 1'b0; value = 32'h0; digit_en = 8'h00;
        repeat (3) step();
        checks++; if (AN !== 8'hFF) begin failures++; $display("FAIL reset_an got=%h exp=ff", AN); end
        checks++; if (digit_out !== 4'h0) begin failures++; $display("FAIL reset_digit got=%h exp=0", digit_out); end
        checks++; if (load_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", load_ack); end
        checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
        reset = 1'b0;
    endtask

    task automatic test_idle;
        logic exp_tick;
        for (int i = 0; i < 128; i++) begin
            exp_tick = (i == 64);
            checks++; if (AN !== 8'hFF) begin failures++; $display("FAIL idle_an c=%0d got=%h exp=ff", i, AN); end
            checks++; if (load_ack !== 1'b0) begin failures++; $display("FAIL idle_ack c=%0d got=%b exp=0", i, load_ack); end
            checks++; if (frame_tick !== exp_tick) begin failures++; $display("FAIL idle_tick c=%0d got=%b exp=%b", i, frame_tick, exp_tick); end
            step();
        end
    endtask

    task automatic test_full_load;
        int k, s;
        logic [7:0] exp_an;
        checks++; if (frame_tick !== 1'b1) begin failures++; $display("FAIL full_start_tick got=%b exp=1", frame_tick); end
        value = 32'h76543210; digit_en = 8'hFF; load = 1'b1;
        step();
        load = 1'b0; value = 32'hDEADBEEF; digit_en = 8'h55;
        for (int p = 1; p < 64; p++) begin
            checks++; if (load_ack !== 1'b0) begin failures++; $display("FAIL full_early_ack p=%0d got=%b exp=0", p, load_ack); end
            checks++; if (AN !== 8'hFF) begin failures++; $display("FAIL full_old_an p=%0d got=%h exp=ff", p, AN); end
            step();
        end
        for (int p = 0; p < 64; p++) begin
            k = p / 8; s = p % 8;
            exp_an = (s < 2) ? 8'hFF : ~(8'h01 << k);
            checks++; if (frame_tick !== (p == 0)) begin failures++; $display("FAIL full_tick p=%0d got=%b", p, frame_tick); end
            checks++; if (load_ack !== (p == 0)) begin failures++; $display("FAIL full_ack p=%0d got=%b", p, load_ack); end
            checks++; if (digit_out !== 4'(k)) begin failures++; $display("FAIL full_digit p=%0d got=%h exp=%h", p, digit_out, k); end
            checks++; if (AN !== exp_an) begin failures++; $display("FAIL full_an p=%0d got=%h exp=%h", p, AN, exp_an); end
            step();
        end
    endtask

    task automatic test_mid_frame;
        int k, s;
        logic [7:0] exp_an;
        logic [3:0] exp_dig;
        for (int p = 0; p < 128; p++) begin
            k = (p % 64) / 8; s = p % 8;
            exp_an  = (s < 2) ? 8'hFF : ~(8'h01 << k);
            exp_dig = (p < 64) ? 4'(k) : 4'hF;
            checks++; if (frame_tick !== (p % 64 == 0)) begin failures++; $display("FAIL mid_tick p=%0d got=%b", p, frame_tick); end
            checks++; if (load_ack !== (p == 64)) begin failures++; $display("FAIL mid_ack p=%0d got=%b", p, load_ack); end
            checks++; if (digit_out !== exp_dig) begin failures++; $display("FAIL mid_digit p=%0d got=%h exp=%h", p, digit_out, exp_dig); end
            checks++; if (AN !== exp_an) begin failures++; $display("FAIL mid_an p=%0d got=%h exp=%h", p, AN, exp_an); end
            if (p == 20) begin value = 32'hFFFFFFFF; digit_en = 8'hFF; load = 1'b1; end
            else load = 1'b0;
            step();
        end
    endtask

    task automatic test_multi_load;
        int k, s, acks;
        logic [7:0] exp_an;
        logic [3:0] exp_dig;
        acks = 0;
        for (int p = 0; p < 128; p++) begin
            k = (p % 64) / 8; s = p % 8;
            exp_an  = (s < 2) ? 8'hFF : ~(8'h01 << k);
            exp_dig = (p < 64) ? 4'hF : ((k == 0) ? 4'h3 : 4'h0);
            if (load_ack === 1'b1) acks++;
            checks++; if (digit_out !== exp_dig) begin failures++; $display("FAIL multi_digit p=%0d got=%h exp=%h", p, digit_out, exp_dig); end
            checks++; if (AN !== exp_an) begin failures++; $display("FAIL multi_an p=%0d got=%h exp=%h", p, AN, exp_an); end
            load = 1'b0;
            if (p == 5)  begin value = 32'h1; digit_en = 8'hFF; load = 1'b1; end
            if (p == 10) begin value = 32'h2; digit_en = 8'hFF; load = 1'b1; end
            if (p == 15) begin value = 32'h3; digit_en = 8'hFF; load = 1'b1; end
            step();
        end
        checks++; if (acks != 1) begin failures++; $display("FAIL multi_ack_count got=%0d exp=1", acks); end
    endtask

    task automatic test_mask;
        int k, s;
        logic [7:0] exp_an;
        logic [3:0] exp_dig;
        for (int p = 0; p < 128; p++) begin
            k = (p % 64) / 8; s = p % 8;
            if (p < 64) begin
                exp_an  = (s < 2) ? 8'hFF : ~(8'h01 << k);
                exp_dig = (k == 0) ? 4'h3 : 4'h0;
            end else begin
                exp_an  = (s >= 2 && (k % 2 == 1)) ? ~(8'h01 << k) : 8'hFF;
                exp_dig = 4'(k);
            end
            checks++; if (frame_tick !== (p % 64 == 0)) begin failures++; $display("FAIL mask_tick p=%0d got=%b", p, frame_tick); end
            checks++; if (load_ack !== (p == 64)) begin failures++; $display("FAIL mask_ack p=%0d got=%b", p, load_ack); end
            checks++; if (digit_out !== exp_dig) begin failures++; $display("FAIL mask_digit p=%0d got=%h exp=%h", p, digit_out, exp_dig); end
            checks++; if (AN !== exp_an) begin failures++; $display("FAIL mask_an p=%0d got=%h exp=%h", p, AN, exp_an); end
            if (p == 0) begin value = 32'h76543210; digit_en = 8'b1010_1010; load = 1'b1; end
            else load = 1'b0;
            step();
        end
    endtask

    task automatic test_boundary_load;
        int k, s;
        logic [7:0] exp_an;
        logic [3:0] exp_dig;
        for (int p = 0; p < 128; p++) begin
            k = (p % 64) / 8; s = p % 8;
            if (p < 64) begin
                exp_an  = (s >= 2 && (k % 2 == 1)) ? ~(8'h01 << k) : 8'hFF;
                exp_dig = 4'(k);
            end else begin
                exp_an  = (s >= 2 && k < 4) ? ~(8'h01 << k) : 8'hFF;
                exp_dig = 4'h2;
            end
            checks++; if (frame_tick !== (p % 64 == 0)) begin failures++; $display("FAIL bnd_tick p=%0d got=%b", p, frame_tick); end
            checks++; if (load_ack !== (p == 64)) begin failures++; $display("FAIL bnd_ack p=%0d got=%b", p, load_ack); end
            checks++; if (digit_out !== exp_dig) begin failures++; $display("FAIL bnd_digit p=%0d got=%h exp=%h", p, digit_out, exp_dig); end
            checks++; if (AN !== exp_an) begin failures++; $display("FAIL bnd_an p=%0d got=%h exp=%h", p, AN, exp_an); end
            load = 1'b0;
            if (p == 30) begin value = 32'h11111111; digit_en = 8'hFF; load = 1'b1; end
            if (p == 63) begin value = 32'h22222222; digit_en = 8'h0F; load = 1'b1; end
            step();
        end
        load = 1'b0;
    endtask

    task automatic test_reset_mid;
        for (int p = 0; p < 12; p++) begin
            load = (p == 3);
            if (p == 3) begin value = 32'h99999999; digit_en = 8'hFF; end
            step();
        end
        load = 1'b0;
        checks++; if (AN !== 8'hFD) begin failures++; $display("FAIL rst_pre_an got=%h exp=fd", AN); end
        reset = 1'b1;
        step();
        checks++; if (AN !== 8'hFF) begin failures++; $display("FAIL rst_an got=%h exp=ff", AN); end
        checks++; if (load_ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", load_ack); end
        checks++; if (digit_out !== 4'h0) begin failures++; $display("FAIL rst_digit got=%h exp=0", digit_out); end
        checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL rst_tick got=%b exp=0", frame_tick); end
        reset = 1'b0;
        for (int i = 0; i <= 64; i++) begin
            checks++; if (AN !== 8'hFF) begin failures++; $display("FAIL rst_post_an c=%0d got=%h exp=ff", i, AN); end
            checks++; if (load_ack !== 1'b0) begin failures++; $display("FAIL rst_post_ack c=%0d got=%b exp=0", i, load_ack); end
            checks++; if (frame_tick !== (i == 64)) begin failures++; $display("FAIL rst_post_tick c=%0d got=%b", i, frame_tick); end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle();
        test_full_load();
        test_mid_frame();
        test_multi_load();
        test_mask();
        test_boundary_load();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
